// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results with FIFO-buffered load results
// onto the register file write port, turning r15 writes into a PC-load strobe.
module wb_arbiter #(
   parameter int DW         = 32,
   parameter int DEPTH      = 4,
   parameter int STARVE_LIM = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          alu_valid,
   input  logic [3:0]    alu_wa,
   input  logic [DW-1:0] alu_wd,
   input  logic          mem_valid,
   output logic          mem_ready,
   input  logic [3:0]    mem_wa,
   input  logic [DW-1:0] mem_wd,
   output logic          we,
   output logic [3:0]    wa,
   output logic [DW-1:0] wd,
   output logic          pc_load,
   output logic [DW-1:0] pc_value,
   output logic [15:0]   pend,
   output logic          alu_hold
);

   localparam int AW = $clog2(DEPTH);
   localparam int SW = $clog2(STARVE_LIM + 1);
   localparam logic [AW:0]   FULL  = (AW + 1)'(DEPTH);
   localparam logic [SW-1:0] LIM_C = SW'(STARVE_LIM);

   typedef struct packed {
      logic [3:0]    wa;
      logic [DW-1:0] wd;
   } ent_t;

   ent_t          mem_q [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   count;
   logic [SW-1:0] starve, starve_nxt;
   logic          popped_q;
   logic          hold_nxt;

   logic          empty, push, pop, win_valid;
   logic [3:0]    win_wa;
   logic [DW-1:0] win_wd;
   ent_t          head;

   logic [DEPTH-1:0][15:0] slot_dec;

   assign empty     = (count == '0);
   assign mem_ready = !reset && (count != FULL);
   assign push      = mem_valid && mem_ready;
   // Count is registered, so a load pushed this edge cannot also pop this edge.
   assign pop       = !alu_valid && !empty;
   assign head      = mem_q[rd_ptr];
   assign win_valid = alu_valid || !empty;
   assign win_wa    = alu_valid ? alu_wa : head.wa;
   assign win_wd    = alu_valid ? alu_wd : head.wd;

   // Each slot contributes a one-hot destination if it lies inside the live window.
   for (genvar g = 0; g < DEPTH; g++) begin : g_slot
      logic [AW-1:0] off;
      assign off         = AW'(g) - rd_ptr;
      assign slot_dec[g] = ({1'b0, off} < count) ? (16'h1 << mem_q[g].wa) : 16'h0;
   end

   always_comb begin
      pend = '0;
      for (int i = 0; i < DEPTH; i++) pend = pend | slot_dec[i];
   end

   always_comb begin
      starve_nxt = starve;
      if (empty || pop)
         starve_nxt = '0;
      else if (alu_valid && starve != LIM_C)
         starve_nxt = starve + 1'b1;
   end

   // Hold is kept through the popping edge and released on the edge after it.
   always_comb begin
      hold_nxt = alu_hold;
      if (starve_nxt == LIM_C)
         hold_nxt = 1'b1;
      else if (popped_q)
         hold_nxt = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr] <= '{wa: mem_wa, wd: mem_wd};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         starve   <= '0;
         popped_q <= 1'b0;
         alu_hold <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         starve   <= starve_nxt;
         popped_q <= pop;
         alu_hold <= hold_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we       <= 1'b0;
         wa       <= '0;
         wd       <= '0;
         pc_load  <= 1'b0;
         pc_value <= '0;
      end else begin
         we      <= 1'b0;
         pc_load <= 1'b0;
         if (win_valid) begin
            if (win_wa == 4'hF) begin
               pc_load  <= 1'b1;
               pc_value <= win_wd;
            end else begin
               we <= 1'b1;
               wa <= win_wa;
               wd <= win_wd;
            end
         end
      end
   end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter that sits directly upstream of the register file's single write port (`we`, `wa`, `wd`). It merges single-cycle ALU results with multi-cycle load results, buffering loads in a small FIFO, and redirects any write to r15 into a PC-load strobe, because the register file holds r0–r14 only. It also exports a per-register pending mask for the hazard logic and requests ALU bubbles when loads are starved.

## Interface
- `DW`, 32: data width.
- `DEPTH`, 4: load FIFO entries (power of two, ≥2).
- `STARVE_LIM`, 8: consecutive cycles a non-empty FIFO may go un-drained before `alu_hold` asserts.

- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `alu_valid`  in  1  ALU result present this cycle; cannot be stalled.
- `alu_wa`  in  4  ALU destination register.
- `alu_wd`  in  DW  ALU result.
- `mem_valid`  in  1  load result offered.
- `mem_ready`  out  1  FIFO can accept; transfer occurs when `mem_valid && mem_ready` at the edge.
- `mem_wa`  in  4  load destination.
- `mem_wd`  in  DW  load data.
- `we`  out  1  register-file write enable (registered).
- `wa`  out  4  register-file write address (registered).
- `wd`  out  DW  register-file write data (registered).
- `pc_load`  out  1  one-cycle strobe: a write targeted r15 (registered).
- `pc_value`  out  DW  new PC, valid while `pc_load` is high (registered).
- `pend`  out  16  bit i is set when any valid FIFO entry has destination i (combinational from FIFO state).
- `alu_hold`  out  1  requests upstream to insert an ALU bubble next cycle (registered).

## Operation
- Each edge selects at most one winner: `alu_valid` has priority; otherwise, if the FIFO is non-empty, it pops the head. Otherwise there is no write.
- Winner with destination 0–14 sets `we=1`, `wa=dest`, and `wd=data` for one cycle, with `pc_load=0`.
- Winner with destination 15 sets `we=0`, `pc_load=1`, and `pc_value=data` for one cycle. `wa` and `wd` hold their previous values.
- With no winner, `we=0` and `pc_load=0`. `wa`, `wd`, and `pc_value` hold.
- FIFO behaviour:
  - Circular buffer with `log2(DEPTH)`-bit read/write pointers that wrap modulo `DEPTH`, plus a count of width `log2(DEPTH)+1`.
  - `mem_ready = !reset && (count != DEPTH)`.
  - Push and pop on the same edge leave the count unchanged.
  - There is no bypass: an entry pushed at edge k is first eligible for pop at edge k+1.
- Starvation counter:
  - Increments on each edge where the FIFO is non-empty and an ALU write wins.
  - Clears on any pop and whenever the FIFO is empty.
  - Saturates at `STARVE_LIM`.
  - `alu_hold` is registered high on the edge where the counter reaches `STARVE_LIM`. It drops on the edge after the next pop.
  - `alu_hold` is advisory: if `alu_valid` stays high, the ALU still wins.
- Write ordering between ALU and loads to the same register is the producers' responsibility. Upstream uses `pend` to stall ALU writes to a pending register.

## Timing
- ALU result accepted at edge k: `we`/`pc_load` is high in the cycle after edge k (latency 1).
- Load pushed at edge k into an empty FIFO with no ALU traffic: popped at edge k+1, so `we` is high after edge k+1 (latency 2).
- `pend` bit sets in the cycle after the push and clears in the cycle after the pop, unless another entry has the same destination.
- Reset values while `reset` is high:
  - `we=0`, `wa=0`, `wd=0`, `pc_load=0`, `pc_value=0`, `alu_hold=0`, `mem_ready=0`, `pend=0`.
  - Count, pointers and starvation counter are 0.
- Reset asserted mid-operation discards all FIFO contents. No partial write is emitted.
- Full FIFO: `mem_ready=0`. A pop at that edge does not admit a same-edge push; `mem_ready` rises the following cycle.
- Back-to-back ALU writes produce `we` high on consecutive cycles.

## Test plan
- **Reset:** assert `reset` mid-cycle with 3 entries queued.
  - Required: all outputs go to 0 immediately, and `pend=0`.
  - After release, `mem_ready=1` and no writes appear.
- **ALU path:** `alu_valid=1`, `alu_wa=3`, `alu_wd=0xDEADBEEF` at edge k.
  - Required: the cycle after k has `we=1`, `wa=3`, `wd=0xDEADBEEF`. The next cycle has `we=0`.
- **r15 redirect:** ALU write with `alu_wa=15`, `alu_wd=0x100`.
  - Required: `we=0`, `pc_load=1`, `pc_value=0x100` for exactly one cycle.
- **Priority and FIFO:** push loads to r1, r2, r3, r4 while `alu_valid` is high for 4 cycles.
  - After 4 pushes: `mem_ready=0` and `pend=0x001E`.
  - Once `alu_valid` drops: writes to r1, r2, r3, r4 appear in order on consecutive cycles.
  - `mem_ready` returns to 1 one cycle after the first pop.
- **Starvation:** one queued load and continuous `alu_valid` (default `STARVE_LIM=8`).
  - Required: `alu_hold=1` after the 8th ALU win.
  - Dropping `alu_valid` for one cycle pops the load, and `alu_hold` returns to 0 on the following edge.
- **Wrap-around:** 10 sequential loads, each pushed and popped singly.
  - Required: all 10 values are written correctly in order across pointer wrap, and `pend` clears to 0 at the end.
